// File: rtl/arm_pipe_pkg.sv
// Shared constants for the ARM core pipeline bundles, plus the width helper
// used to size occupancy counters.
package arm_pipe_pkg;

    // Packed payload widths of the per-stage bundles handed to elastic_pipe
    localparam int IF_STAGE_W  = 64;
    localparam int ID_STAGE_W  = 112;
    localparam int EXE_STAGE_W = 144;
    localparam int MEM_STAGE_W = 104;

    // Ceiling log2 with a floor of 1 so a count of 0..value-1 always fits
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry output skid buffer: main register drives the consumer, spare catches
// the one item in flight when main stalls. Upstream ready is purely registered.
module skid_buffer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o
);

    logic              main_v_q, main_v_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              spare_v_q, spare_v_d;
    logic [DATA_W-1:0] spare_data_q, spare_data_d;
    logic              in_fire;
    logic              out_fire;

    assign ready_o  = !spare_v_q;
    assign valid_o  = main_v_q;
    assign data_o   = main_data_q;
    assign in_fire  = valid_i && !spare_v_q;
    assign out_fire = main_v_q && ready_i;

    always_comb begin
        main_v_d     = main_v_q;
        main_data_d  = main_data_q;
        spare_v_d    = spare_v_q;
        spare_data_d = spare_data_q;
        if (flush) begin
            main_v_d  = 1'b0;
            spare_v_d = 1'b0;
        end else if (!main_v_q || out_fire) begin
            // Spare is always older than anything arriving, so it drains first
            if (spare_v_q) begin
                main_v_d    = 1'b1;
                main_data_d = spare_data_q;
                spare_v_d   = 1'b0;
            end else begin
                main_v_d = in_fire;
                if (in_fire) begin
                    main_data_d = data_i;
                end
            end
        end else if (in_fire) begin
            spare_v_d    = 1'b1;
            spare_data_d = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_v_q    <= 1'b0;
            main_data_q <= '0;
            spare_v_q   <= 1'b0;
        end else begin
            main_v_q    <= main_v_d;
            main_data_q <= main_data_d;
            spare_v_q   <= spare_v_d;
        end
        spare_data_q <= spare_data_d;
    end

endmodule

// File: rtl/elastic_pipe.sv
// Parametrised valid/ready register chain with bubble collapsing, flush,
// optional output skid buffer and an occupancy counter.
module elastic_pipe
    import arm_pipe_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int STAGES = 1,
    parameter  int SKID   = 0,
    localparam int OCC_W  = clog2(STAGES + 2 * SKID + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occupancy
);

    logic [STAGES-1:0] stage_v;
    logic [DATA_W-1:0] stage_d [STAGES];
    logic [STAGES-1:0] adv;
    logic              ds_ready;
    logic              in_fire;
    logic              out_fire;
    logic [OCC_W-1:0]  occ_q, occ_d;

    // A stage advances if it is empty or its successor advances
    always_comb begin
        logic chain;
        chain = ds_ready;
        adv   = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            chain  = !stage_v[k] || chain;
            adv[k] = chain;
        end
    end

    assign in_ready = adv[0] && !flush;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic              valid_q;
            logic [DATA_W-1:0] data_q;
            logic              src_v;
            logic [DATA_W-1:0] src_d;

            if (gi == 0) begin : g_src_in
                assign src_v = in_valid;
                assign src_d = in_data;
            end else begin : g_src_prev
                assign src_v = stage_v[gi-1];
                assign src_d = stage_d[gi-1];
            end

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    valid_q <= 1'b0;
                end else if (adv[gi]) begin
                    valid_q <= src_v;
                end
            end

            // Data only moves with a valid source, so no stale value reaches the output
            always_ff @(posedge clk) begin
                if (rst && (gi == STAGES - 1)) begin
                    data_q <= '0;
                end else if (adv[gi] && src_v) begin
                    data_q <= src_d;
                end
            end

            assign stage_v[gi] = valid_q;
            assign stage_d[gi] = data_q;
        end

        if (SKID != 0) begin : g_skid
            skid_buffer #(
                .DATA_W (DATA_W)
            ) u_skid (
                .clk     (clk),
                .rst     (rst),
                .flush   (flush),
                .valid_i (stage_v[STAGES-1]),
                .ready_o (ds_ready),
                .data_i  (stage_d[STAGES-1]),
                .valid_o (out_valid),
                .ready_i (out_ready),
                .data_o  (out_data)
            );
        end else begin : g_direct
            assign ds_ready  = out_ready;
            assign out_valid = stage_v[STAGES-1];
            assign out_data  = stage_d[STAGES-1];
        end
    endgenerate

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (in_fire && !out_fire) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!in_fire && out_fire) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_elastic_pipe.sv
// Directed checks of elastic_pipe in three configurations:
// a = 3 stages no skid, b = 3 stages with skid, c = 4 stages no skid.
module tb_elastic_pipe;

    logic        clk;
    logic        rst;
    logic        flush;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_occ;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [2:0]  b_occ;

    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [31:0] c_in_data, c_out_data;
    logic [2:0]  c_occ;

    int n_checks;
    int n_errors;

    elastic_pipe #(.DATA_W(32), .STAGES(3), .SKID(0)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ)
    );

    elastic_pipe #(.DATA_W(32), .STAGES(3), .SKID(1)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ)
    );

    elastic_pipe #(.DATA_W(32), .STAGES(4), .SKID(0)) dut_c (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .occupancy(c_occ)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 unit after the edge; outputs are read 3 units later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int accepts;
        int rcv;
        int exp_occ;
        logic exp_v;

        n_checks = 0;
        n_errors = 0;
        clk = 1'b0;
        rst = 1'b1;
        flush = 1'b0;
        a_in_valid = 1'b1; a_in_data = 32'h55; a_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_data = 32'h55; b_out_ready = 1'b0;
        c_in_valid = 1'b1; c_in_data = 32'h55; c_out_ready = 1'b0;

        // 1: reset held two cycles with input offered
        tick();
        tick();
        settle();
        check_eq("rst_a_out_valid", a_out_valid, 0);
        check_eq("rst_a_out_data", a_out_data, 0);
        check_eq("rst_a_occ", a_occ, 0);
        check_eq("rst_b_out_valid", b_out_valid, 0);
        check_eq("rst_b_out_data", b_out_data, 0);
        check_eq("rst_b_occ", b_occ, 0);
        check_eq("rst_c_out_valid", c_out_valid, 0);
        check_eq("rst_c_out_data", c_out_data, 0);
        tick();
        rst = 1'b0;
        a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
        settle();
        check_eq("post_rst_a_in_ready", a_in_ready, 1);
        check_eq("post_rst_b_in_ready", b_in_ready, 1);
        check_eq("post_rst_c_in_ready", c_in_ready, 1);
        check_eq("post_rst_a_occ", a_occ, 0);
        check_eq("post_rst_b_occ", b_occ, 0);

        // 2: stream 0x1..0xA through 3 stages, consumer always ready
        a_out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            tick();
            a_in_valid = (c < 10);
            a_in_data  = 32'(c + 1);
            settle();
            exp_v   = (c >= 3) && (c < 13);
            exp_occ = (c < 3) ? c : ((c <= 10) ? 3 : 13 - c);
            check_eq($sformatf("stream_in_ready_c%0d", c), a_in_ready, 1);
            check_eq($sformatf("stream_out_valid_c%0d", c), a_out_valid, exp_v);
            check_eq($sformatf("stream_occ_c%0d", c), a_occ, exp_occ);
            if (exp_v) begin
                check_eq($sformatf("stream_out_data_c%0d", c), a_out_data, 32'(c - 2));
                $display("stream a: cycle %0d out_data=0x%0h", c, a_out_data);
            end
        end

        // 3: backpressure into the skid configuration
        b_out_ready = 1'b0;
        accepts = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            b_in_valid = 1'b1;
            b_in_data  = 32'h10 + 32'(accepts);
            settle();
            if (b_in_ready) begin
                $display("bp b: accept data=0x%0h", b_in_data);
                accepts++;
            end
        end
        check_eq("bp_accepts", 32'(accepts), 5);
        check_eq("bp_in_ready_full", b_in_ready, 0);
        check_eq("bp_occ_full", b_occ, 5);
        check_eq("bp_hold_valid", b_out_valid, 1);
        check_eq("bp_hold_data", b_out_data, 32'h10);
        rcv = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            b_in_valid  = 1'b0;
            b_out_ready = 1'b1;
            settle();
            if (b_out_valid) begin
                check_eq($sformatf("bp_drain_data_%0d", rcv), b_out_data, 32'h10 + 32'(rcv));
                $display("bp b: drain out_data=0x%0h", b_out_data);
                rcv++;
            end
        end
        check_eq("bp_drain_count", 32'(rcv), 5);
        check_eq("bp_drain_occ", b_occ, 0);

        // 4: bubbles collapse toward the tail of a 4-stage pipe
        c_out_ready = 1'b0;
        for (int c = 0; c < 9; c++) begin
            tick();
            c_in_valid = (c == 0) || (c == 3);
            c_in_data  = (c == 0) ? 32'hA : 32'hB;
            settle();
        end
        check_eq("bubble_occ", c_occ, 2);
        check_eq("bubble_out_valid", c_out_valid, 1);
        check_eq("bubble_out_data", c_out_data, 32'hA);
        check_eq("bubble_in_ready", c_in_ready, 1);
        tick();
        c_in_valid  = 1'b0;
        c_out_ready = 1'b1;
        settle();
        check_eq("bubble_first_valid", c_out_valid, 1);
        check_eq("bubble_first_data", c_out_data, 32'hA);
        $display("bubble c: out_data=0x%0h", c_out_data);
        tick();
        settle();
        check_eq("bubble_second_valid", c_out_valid, 1);
        check_eq("bubble_second_data", c_out_data, 32'hB);
        $display("bubble c: out_data=0x%0h", c_out_data);
        tick();
        settle();
        check_eq("bubble_empty_valid", c_out_valid, 0);
        check_eq("bubble_empty_occ", c_occ, 0);

        // 5: flush with three entries held and a competing input
        a_out_ready = 1'b0;
        b_out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            a_in_valid = 1'b1; a_in_data = 32'h21 + 32'(c);
            b_in_valid = 1'b1; b_in_data = 32'h21 + 32'(c);
            settle();
        end
        tick();
        flush = 1'b1;
        a_in_data = 32'hDEAD;
        b_in_data = 32'hDEAD;
        settle();
        check_eq("flush_a_occ_before", a_occ, 3);
        check_eq("flush_b_occ_before", b_occ, 3);
        check_eq("flush_a_in_ready", a_in_ready, 0);
        check_eq("flush_b_in_ready", b_in_ready, 0);
        tick();
        flush = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        settle();
        check_eq("flush_a_out_valid", a_out_valid, 0);
        check_eq("flush_a_occ", a_occ, 0);
        check_eq("flush_b_out_valid", b_out_valid, 0);
        check_eq("flush_b_occ", b_occ, 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            settle();
            check_eq($sformatf("flush_a_quiet_%0d", c), a_out_valid, 0);
            check_eq($sformatf("flush_b_quiet_%0d", c), b_out_valid, 0);
        end

        // 6: reset while full and stalled, then a fresh stream through the skid
        b_out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            b_in_valid = 1'b1;
            b_in_data  = 32'h30 + 32'(c);
            settle();
        end
        check_eq("midrst_occ_full", b_occ, 5);
        tick();
        rst = 1'b1;
        b_in_valid = 1'b0;
        settle();
        tick();
        rst = 1'b0;
        settle();
        check_eq("midrst_out_valid", b_out_valid, 0);
        check_eq("midrst_out_data", b_out_data, 0);
        check_eq("midrst_occ", b_occ, 0);
        check_eq("midrst_in_ready", b_in_ready, 1);
        for (int c = 0; c < 10; c++) begin
            tick();
            b_in_valid  = (c < 5);
            b_in_data   = 32'h100 + 32'(c);
            b_out_ready = 1'b1;
            settle();
            exp_v = (c >= 4) && (c < 9);
            check_eq($sformatf("fresh_out_valid_c%0d", c), b_out_valid, exp_v);
            if (exp_v) begin
                check_eq($sformatf("fresh_out_data_c%0d", c), b_out_data, 32'h100 + 32'(c - 4));
                $display("fresh b: cycle %0d out_data=0x%0h", c, b_out_data);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
